// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_rx
// Purpose  : Receive-only SPI slave; synchronised SCLK/MOSI/CS_n deserialised
//            into bytes, buffered in a FIFO, read over a 16-bit CPU word port.
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] datain,
    output logic [15:0] dataout,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    output logic        irq
);

    localparam int       AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] c_ptr_one = 1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic                   r_armed;

    logic                   r_en;
    logic                   r_edge;
    logic                   r_ie;
    logic                   r_ovr;

    logic [2:0]             r_bcnt;
    logic [6:0]             r_sreg;

    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_rd_ptr;

    logic [15:0]            r_dataout;
    logic                   r_irq;

    logic w_sclk_s, w_mosi_s, w_cs_s;
    logic w_rise, w_fall, w_sample;
    logic w_active;
    logic w_push, w_pop, w_flush, w_ovr_clr;
    logic w_empty, w_full;
    logic w_push_ok, w_ovr_set;
    logic [7:0] w_push_data;
    logic [7:0] w_head;
    logic w_unused_datain;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

    assign w_rise   = w_sclk_s & ~r_sclk_prev;
    assign w_fall   = ~w_sclk_s & r_sclk_prev;
    assign w_sample = r_edge ? w_fall : w_rise;

    // r_armed blocks reception after reset until cs_n has been seen high once.
    assign w_active    = r_en & ~w_cs_s & r_armed;
    assign w_push      = w_active & w_sample & (r_bcnt == 3'd7);
    assign w_push_data = {r_sreg, w_mosi_s};

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_flush   = ~wr_n & datain[7];
    assign w_ovr_clr = ~wr_n & datain[6];
    assign w_pop     = ~rd_n & ~w_empty;
    assign w_push_ok = w_push & (~w_full | w_pop) & ~w_flush;
    assign w_ovr_set = w_push & w_full & ~w_pop & ~w_flush;

    assign w_head = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

    assign w_unused_datain = ^{datain[15:8], datain[5:3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '0;
            r_sclk_prev <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sclk_prev <= w_sclk_s;
            if (w_cs_s)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en   <= 1'b0;
            r_edge <= 1'b0;
            r_ie   <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (!wr_n) begin
                r_en   <= datain[0];
                r_edge <= datain[1];
                r_ie   <= datain[2];
            end
            if (w_ovr_set)
                r_ovr <= 1'b1;
            else if (w_ovr_clr)
                r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt <= 3'd0;
            r_sreg <= 7'd0;
        end else if (!w_active) begin
            r_bcnt <= 3'd0;
            r_sreg <= 7'd0;
        end else if (w_sample) begin
            r_sreg <= {r_sreg[5:0], w_mosi_s};
            r_bcnt <= r_bcnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= 8'h00;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    // Status/data snapshot lags the FIFO state by one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dataout <= 16'h0000;
            r_irq     <= 1'b0;
        end else begin
            r_dataout <= {w_head, (r_bcnt != 3'd0), ~w_cs_s, r_ovr, w_full,
                          ~w_empty, r_ie, r_edge, r_en};
            r_irq     <= r_ie & ~w_empty;
        end
    end

    assign dataout = r_dataout;
    assign irq     = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_rx
// Purpose  : Directed self-checking bench for spi_slave_rx.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_rx;

    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] datain = 16'h0000;
    logic [15:0] dataout;
    logic        wr_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    spi_slave_rx #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .datain(datain), .dataout(dataout),
        .wr_n(wr_n), .rd_n(rd_n), .sclk(sclk), .mosi(mosi),
        .cs_n(cs_n), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [7:0] v);
        @(negedge clk);
        datain = {8'h00, v};
        wr_n   = 1'b0;
        @(negedge clk);
        wr_n   = 1'b1;
    endtask

    task automatic cpu_pop();
        @(negedge clk);
        rd_n = 1'b0;
        @(negedge clk);
        rd_n = 1'b1;
    endtask

    // Top n bits of b, MSB first, 8 clk per bit. fall_mode: mosi changes on
    // the rising edge and is sampled on the falling one.
    task automatic send_bits(input logic [7:0] b, input int n, input bit fall_mode);
        for (int i = 7; i > 7 - n; i--) begin
            if (fall_mode) begin
                sclk = 1'b1;
                mosi = b[i];
                wait_clk(4);
                sclk = 1'b0;
                wait_clk(4);
            end else begin
                mosi = b[i];
                wait_clk(4);
                sclk = 1'b1;
                wait_clk(4);
                sclk = 1'b0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fall_mode);
        send_bits(b, 8, fall_mode);
        wait_clk(8);
    endtask

    task automatic check_word(input string name, input logic [15:0] exp);
        n_total++;
        if (dataout !== exp)
            $display("FAIL %s: dataout=%h expected=%h", name, dataout, exp);
        else
            n_pass++;
    endtask

    task automatic check_irq(input string name, input logic exp);
        n_total++;
        if (irq !== exp)
            $display("FAIL %s: irq=%b expected=%b", name, irq, exp);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        wait_clk(3);
        check_word("reset_dataout", 16'h0000);
        check_irq("reset_irq", 1'b0);
        rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_basic();
        cpu_write(8'h05);
        cs_n = 1'b0;
        wait_clk(6);
        send_byte(8'hA5, 1'b0);
        check_word("basic_rx", 16'hA54D);
        check_irq("basic_irq", 1'b1);
        cpu_pop();
        wait_clk(4);
        check_word("basic_pop", 16'h0045);
        check_irq("basic_irq_clr", 1'b0);
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        for (int i = 1; i <= 5; i++) begin
            exp_b = 8'(i);
            send_byte(exp_b, 1'b0);
        end
        check_word("ovf_full", 16'h017D);
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            n_total++;
            if (dataout[15:8] !== exp_b)
                $display("FAIL ovf_pop%0d: head=%h expected=%h", i, dataout[15:8], exp_b);
            else
                n_pass++;
            cpu_pop();
            wait_clk(4);
        end
        check_word("ovf_empty", 16'h0065);
        cpu_write(8'h41);
        wait_clk(3);
        check_word("ovf_clear", 16'h0041);
    endtask

    task automatic test_partial();
        cpu_write(8'h05);
        cs_n = 1'b1;
        wait_clk(6);
        cs_n = 1'b0;
        wait_clk(6);
        send_bits(8'hB0, 5, 1'b0);
        wait_clk(6);
        check_word("partial_busy", 16'h00C5);
        cs_n = 1'b1;
        wait_clk(6);
        check_word("partial_drop", 16'h0005);
        cs_n = 1'b0;
        wait_clk(6);
        send_byte(8'h3C, 1'b0);
        check_word("partial_rx", 16'h3C4D);
        cpu_pop();
        wait_clk(4);
        check_word("partial_one", 16'h0045);
    endtask

    task automatic test_falling();
        cpu_write(8'h03);
        wait_clk(4);
        send_byte(8'h96, 1'b1);
        check_word("falling_rx", 16'h964B);
        cpu_pop();
        wait_clk(4);
        check_word("falling_pop", 16'h0043);
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_b;
        cpu_write(8'h05);
        wait_clk(4);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check_word("pp_full", 16'h115D);
        send_bits(8'h55, 7, 1'b0);
        mosi = 1'b1;
        wait_clk(4);
        sclk = 1'b1;
        // Push lands on the SYNC_STAGES+1-th rising clk edge after the toggle.
        wait_clk(SYNC_STAGES);
        rd_n = 1'b0;
        wait_clk(1);
        rd_n = 1'b1;
        wait_clk(1);
        sclk = 1'b0;
        wait_clk(8);
        check_word("pp_same_cycle", 16'h225D);
        for (int i = 2; i <= 5; i++) begin
            exp_b = 8'(i * 17);
            n_total++;
            if (dataout[15:8] !== exp_b)
                $display("FAIL pp_pop%0d: head=%h expected=%h", i, dataout[15:8], exp_b);
            else
                n_pass++;
            cpu_pop();
            wait_clk(4);
        end
        check_word("pp_empty", 16'h0045);
    endtask

    task automatic test_flush();
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        check_word("flush_pre", 16'h774D);
        cpu_write(8'h85);
        wait_clk(3);
        check_word("flush_post", 16'h0045);
        check_irq("flush_irq", 1'b0);
    endtask

    task automatic test_reset_midbyte();
        send_bits(8'hFF, 3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_word("midrst_dataout", 16'h0000);
        check_irq("midrst_irq", 1'b0);
        wait_clk(3);
        rst = 1'b0;
        cpu_write(8'h05);
        wait_clk(4);
        send_byte(8'hC3, 1'b0);
        n_total++;
        if (dataout[3] !== 1'b0)
            $display("FAIL midrst_unarmed: rxrdy=%b expected=0", dataout[3]);
        else
            n_pass++;
        cs_n = 1'b1;
        wait_clk(6);
        cs_n = 1'b0;
        wait_clk(6);
        send_byte(8'h5A, 1'b0);
        check_word("midrst_rx", 16'h5A4D);
        cpu_pop();
        wait_clk(4);
        check_word("midrst_only", 16'h0045);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_partial();
        test_falling();
        test_push_pop_full();
        test_flush();
        test_reset_midbyte();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
